// File: rtl/d_flip_flop_pkg.sv
// Shared datapath constants and types for the 3x3 convolution PE array.
package d_flip_flop_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned DATA_W = PIX_W + 1;
  localparam int unsigned COEF_W = 8;

  typedef logic        [DATA_W-1:0] data_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  // Unsigned pixels enter the 9-bit datapath with a zero MSB.
  function automatic data_t zext_pixel(input logic [PIX_W-1:0] pix);
    return {1'b0, pix};
  endfunction

endpackage

// File: rtl/d_flip_flop_chain.sv
// N-stage delay line built from d_flip_flop; one shared enable keeps taps aligned.
module d_flip_flop_chain
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned STAGES = 2
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           en_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [STAGES-1:0][WIDTH-1:0]   taps_o
);

  if (STAGES < 1) begin : g_bad_stages
    $error("d_flip_flop_chain: STAGES must be at least 1");
  end

  // link[0] is the live input; link[i+1] is the output of stage i.
  logic [STAGES:0][WIDTH-1:0] link;

  // Feed the chain head from the external input.
  always_comb begin
    link[0] = data_i;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    d_flip_flop #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .en_i    (en_i),
      .data_i  (link[i]),
      .data_o  (link[i+1])
    );
  end

  // Tap k is the input delayed by k+1 enabled cycles.
  always_comb begin
    taps_o = link[STAGES:1];
  end

endmodule

// File: rtl/sign_extend.sv
// Widens a two's-complement coefficient by one bit to match the datapath.
module sign_extend
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned LEN = COEF_W
) (
  input  logic [LEN-1:0] in,
  output logic [LEN:0]   out
);

  if (LEN < 1) begin : g_bad_len
    $error("sign_extend: LEN must be at least 1");
  end

  // Replicate the sign bit above the untouched input bits.
  always_comb begin
    out = {in[LEN-1], in};
  end

endmodule

// File: rtl/d_flip_flop.sv
// Enabled, synchronously reset register stage used as a pixel delay tap.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (WIDTH < 1) begin : g_bad_width
    $error("d_flip_flop: WIDTH must be at least 1");
  end

  // Reset wins over enable; with enable low the stage holds (stall).
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      data_o <= '0;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench: stimulus pushes expected post-edge values, monitor pops and compares.
module tb_d_flip_flop;

  logic        clk;
  logic        rst;
  logic        en;
  logic [8:0]  d9;
  logic [0:0]  d1;
  logic [15:0] d16;
  logic [8:0]  q9;
  logic [0:0]  q1;
  logic [15:0] q16;
  logic [1:0][8:0] taps;

  logic [7:0]  se8_in;
  logic [8:0]  se8_out;
  logic [3:0]  se4_in;
  logic [4:0]  se4_out;
  logic [11:0] se12_in;
  logic [12:0] se12_out;

  int n_cmp = 0;
  int n_bad = 0;

  d_flip_flop dut (
    .clock_i (clk), .reset_i (rst), .en_i (en), .data_i (d9), .data_o (q9)
  );

  d_flip_flop #(.WIDTH(1)) dut_w1 (
    .clock_i (clk), .reset_i (rst), .en_i (en), .data_i (d1), .data_o (q1)
  );

  d_flip_flop #(.WIDTH(16)) dut_w16 (
    .clock_i (clk), .reset_i (rst), .en_i (en), .data_i (d16), .data_o (q16)
  );

  d_flip_flop_chain #(.WIDTH(9), .STAGES(2)) u_chain (
    .clock_i (clk), .reset_i (rst), .en_i (en), .data_i (d9), .taps_o (taps)
  );

  sign_extend se8 (.in (se8_in), .out (se8_out));
  sign_extend #(.LEN(4))  se4  (.in (se4_in),  .out (se4_out));
  sign_extend #(.LEN(12)) se12 (.in (se12_in), .out (se12_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  e9;
    logic [0:0]  e1;
    logic [15:0] e16;
    logic [8:0]  t1;
    logic [8:0]  t2;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: last loaded value per register, and history of accepted samples.
  logic [8:0]  m9;
  logic [0:0]  m1;
  logic [15:0] m16;
  logic [8:0]  hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Value of a LEN-bit two's-complement code, re-encoded in LEN+1 bits.
  function automatic logic [31:0] sext_ref(input longint unsigned v, input int unsigned len);
    longint s;
    if (((v >> (len - 1)) & 1) != 0) s = longint'(v) - (longint'(1) << len);
    else s = longint'(v);
    return 32'(s & ((longint'(1) << (len + 1)) - 1));
  endfunction

  task automatic step(input logic r, input logic e, input logic [8:0] d);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    d9  = d;
    d1  = 1'($urandom);
    d16 = 16'($urandom);
    if (r) begin
      m9 = '0; m1 = '0; m16 = '0;
      hist.delete();
    end else if (e) begin
      m9 = d; m1 = d1; m16 = d16;
      hist.push_back(d);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    x.e9  = m9;
    x.e1  = m1;
    x.e16 = m16;
    x.t1  = (hist.size() >= 1) ? hist[hist.size()-1] : 9'd0;
    x.t2  = (hist.size() >= 2) ? hist[hist.size()-2] : 9'd0;
    exp_q.push_back(x);
  endtask

  // Monitor: each edge presents a new register value; compare against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("q9",   32'(q9),      32'(x.e9));
        check("q1",   32'(q1),      32'(x.e1));
        check("q16",  32'(q16),     32'(x.e16));
        check("tap1", 32'(taps[0]), 32'(x.t1));
        check("tap2", 32'(taps[1]), 32'(x.t2));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] se_in_tab [5];
    logic [8:0] se_out_tab[5];
    rst = 1'b1; en = 1'b0; d9 = '0; d1 = '0; d16 = '0;
    se8_in = '0; se4_in = '0; se12_in = '0;

    // Combinational sign extension, directed then random.
    se_in_tab  = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'd52};
    se_out_tab = '{9'h07F, 9'h180, 9'h1FF, 9'h000, 9'd52};
    for (int i = 0; i < 5; i++) begin
      se8_in = se_in_tab[i];
      #1;
      check("sext8_dir", 32'(se8_out), 32'(se_out_tab[i]));
    end
    se4_in = 4'h8; #1; check("sext4_min", 32'(se4_out), 32'h18);
    se4_in = 4'h7; #1; check("sext4_max", 32'(se4_out), 32'h07);
    for (int i = 0; i < 200; i++) begin
      se8_in  = 8'($urandom);
      se4_in  = 4'($urandom);
      se12_in = 12'($urandom);
      #1;
      check("sext8",  32'(se8_out),  sext_ref(longint'(se8_in), 8));
      check("sext4",  32'(se4_out),  sext_ref(longint'(se4_in), 4));
      check("sext12", 32'(se12_out), sext_ref(longint'(se12_in), 12));
    end

    // Reset held with enable and all-ones data.
    step(1'b1, 1'b1, 9'h1FF);
    step(1'b1, 1'b1, 9'h1FF);
    // Load, stall, resume.
    step(1'b0, 1'b1, 9'd16);
    step(1'b0, 1'b0, 9'd255);
    step(1'b0, 1'b0, 9'd255);
    step(1'b0, 1'b0, 9'd255);
    step(1'b0, 1'b1, 9'd255);
    // Mid-stream reset discards the presented data.
    step(1'b0, 1'b1, 9'd200);
    step(1'b1, 1'b1, 9'd7);
    step(1'b0, 1'b1, 9'd7);
    // Tap line with a two-cycle stall.
    step(1'b0, 1'b1, 9'd1);
    step(1'b0, 1'b1, 9'd2);
    step(1'b0, 1'b1, 9'd16);
    step(1'b0, 1'b1, 9'd4);
    step(1'b0, 1'b0, 9'd9);
    step(1'b0, 1'b0, 9'd9);
    step(1'b0, 1'b1, 9'd5);
    step(1'b0, 1'b1, 9'd6);
    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 9'($urandom));
    end

    repeat (4) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/d_flip_flop.md
# d_flip_flop

Enabled, synchronously reset register stage used as the pixel delay element in the 3x3 convolution processing-element array. Chaining two stages per filter row forms the horizontal tap line: taps at the input, after one cycle and after two cycles. The companion leaf `sign_extend` widens 8-bit filter coefficients by one bit so they match the 9-bit datapath.

## Interface
- `WIDTH`, default 9: register data width, in bits.
- `LEN`, default 8: `sign_extend` input width; its output is LEN+1 bits.
- `clock_i`, input, 1: single clock; all state changes on the rising edge.
- `reset_i`, input, 1: reset, synchronous and active-high.
- `en_i`, input, 1: load enable.
- `data_i`, input, WIDTH: next value to register.
- `data_o`, output, WIDTH: registered value.
- `sign_extend` ports, purely combinational:
  - `in`, input, LEN
  - `out`, output, LEN+1

## Operation
- Register, evaluated at each rising edge of `clock_i`, in priority order:
  - `reset_i`=1: `data_o` <= 0. Reset beats `en_i`.
  - else `en_i`=1: `data_o` <= `data_i`.
  - else: `data_o` holds its value.
- Power-up value is unspecified until the first reset edge; users must reset before use.
- The register is data-agnostic: no arithmetic, no sign interpretation. Callers zero-extend unsigned pixels (`{1'b0, pixel}`) before loading.
- `sign_extend`: `out = {in[LEN-1], in}`.
  - `out[LEN-1:0]` equals `in` exactly.
  - `out[LEN]` copies the MSB of `in`.
  - No clock, no reset, no state.
- Default `LEN`=8 maps a two's-complement coefficient in −128..127 to the same value in 9 bits.

## Timing
- `data_o` is one-cycle latency from `data_i`, gated by `en_i` sampled at the same edge.
- `en_i` low stalls the stage. A chain of N stages sharing `en_i` stalls coherently, so the taps stay aligned across stalls.
- Reset held for any number of cycles keeps `data_o`=0.
- First enabled load after reset deasserts lands on the next edge.
- Reset mid-stream clears the value at that edge. Data presented during the reset cycle is discarded, not captured later.
- `data_i` and `en_i` changing between edges have no effect until the next edge. There is no combinational path from `data_i` to `data_o`.
- `sign_extend` has zero latency. `out` settles combinationally whenever `in` changes.

## Structure
- Shared package: `PIX_W`=8, `DATA_W`=9 (= `PIX_W`+1), `COEF_W`=8.
  - Typedef `data_t` for the 9-bit datapath word.
  - Typedef `coef_t` for signed 8-bit coefficients.
  - `WIDTH` and `LEN` defaults reference these constants.
- `sign_extend` is the one natural sibling leaf, kept in its own module. The convolution unit instantiates one per coefficient: nine per 3x3 filter.
- `d_flip_flop` has no sub-modules. It is instantiated two per filter row, six per 3x3 array, all sharing one enable.
- A generate-based N-stage `d_flip_flop` chain may wrap both modules for the array. Including the parameter checks, this keeps the RTL for the pair plus wrapper in the 120–400 line range.

## Test plan
- Reset: hold `reset_i`=1 with `en_i`=1 and `data_i`=9'h1FF for 2 edges → `data_o`=0 after the first edge and stays 0.
- Load and hold:
  - After reset, `en_i`=1, `data_i`=9'd16 → `data_o`=16 at the next edge.
  - Then `en_i`=0, `data_i`=9'd255 for 3 edges → `data_o` stays 16.
  - Then `en_i`=1 → 255 after one edge.
- Mid-stream reset: `data_o`=200 with `en_i`=1 and `data_i`=7, `reset_i`=1 for one edge → `data_o`=0. Next edge with reset released → 7.
- Two-stage chain, shared enable:
  - Drive pixels 1, 2, 16, 4 on consecutive edges → stage-1 output lags the input by 1 cycle and stage-2 output lags by 2 (16 appears at stage 2 two edges after being driven).
  - Drop the enable for 2 cycles → both outputs freeze and resume aligned.
- `sign_extend`, `LEN`=8:
  - 8'h7F → 9'h07F
  - 8'h80 → 9'h180
  - 8'hFF → 9'h1FF
  - 8'h00 → 9'h000
  - 8'd52 → 9'd52
  - All outputs are immediate, with no clock applied.
- Parameter sweep: `WIDTH`=1 and `WIDTH`=16, `LEN`=4 and `LEN`=12, each with random stimulus against a reference model of the priority rules and the extension formula; 1000 cycles with zero mismatches.
